gb_frame_scaler: RTL and testbench
==================================

Name: gb_frame_scaler

Overview:
- Sits directly upstream of the display colour path: it stores the Game Boy PPU's 160x144 2-bit pixel stream in an internal framebuffer.
- It watches the hsync/vsync/de produced by the LCD timing generator and returns a delayed, aligned hsync/vsync/de plus the RGB565 colour for each active pixel.
- Image is integer-upscaled (3x -> 480x432) and vertically centred with a border colour fill.
- Single clock: the display pixel clock; PPU writes are presented already in this domain.

Parameters:
- GB_W, 160, source pixels per line
- GB_H, 144, source lines per frame
- SCALE, 3, integer replication factor, horizontal and vertical
- WIDTH, 480, active display pixels per line
- HEIGHT, 480, active display lines per frame
- V_OFFSET, 24, first display row carrying image, equal to (HEIGHT-GB_H*SCALE)/2
- H_OFFSET, 0, first display column carrying image
- BORDER_COLOR, 16'h0000, RGB565 value outside the image window

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  PPU pixel write strobe
- wr_pixel  in  2  shade 0..3, 0 = lightest
- wr_frame_start  in  1  restarts the write address at 0
- wr_overflow  out  1  sticky: a write was attempted past GB_W*GB_H-1
- hsync_in  in  1  from timing generator, active low
- vsync_in  in  1  from timing generator, active low
- de_in  in  1  from timing generator, active high
- hsync  out  1  hsync_in delayed 2 cycles
- vsync  out  1  vsync_in delayed 2 cycles
- de  out  1  de_in delayed 2 cycles
- color  out  16  RGB565, aligned with de

Behaviour:
- Reset (async, active high) forces:
  - hsync = 1, vsync = 1, de = 0, color = 0, wr_overflow = 0
  - write address and all read counters cleared
  - framebuffer contents are not cleared
- Framebuffer is GB_W*GB_H entries x 2 bits, single-port write and single-port read (BRAM inference).
- Write side:
  - wr_frame_start loads the write address with 0.
  - If wr_en is high in the same cycle, the pixel is written to address 0 and the address becomes 1.
  - Otherwise each wr_en writes at the current address, then the address increments.
  - At address GB_W*GB_H the address saturates; further writes are dropped and set wr_overflow.
  - wr_overflow clears only on reset.
- Read-address generation (no multiplier or divider):
  - Counters: col, h_phase (0..SCALE-1), src_x, row, v_phase, src_y, line_base.
  - While de_in = 1: col increments.
  - Inside the horizontal window, h_phase increments; when it wraps, src_x increments.
  - Falling edge of de_in (end of line): col, h_phase and src_x clear; row increments.
  - Inside the vertical window, v_phase increments; when it wraps, src_y increments and line_base += GB_W.
  - vsync_in = 0: row, v_phase, src_y and line_base clear.
  - Read address = line_base + src_x.
- Windows:
  - Horizontal window: H_OFFSET <= col < H_OFFSET + GB_W*SCALE.
  - Vertical window: V_OFFSET <= row < V_OFFSET + GB_H*SCALE.
- Pipeline, 2 cycles total:
  - Stage 1: memory read plus registered in_window flag; hsync/vsync/de delayed by one stage.
  - Stage 2: palette lookup into color; the second stage of delay drives hsync/vsync/de.
- Colour output:
  - de = 0: color = 0.
  - de = 1 and in window: color = palette[shade].
  - de = 1 and outside window: color = BORDER_COLOR.
- Palette: shade0 16'hFFFF, shade1 16'hAD55, shade2 16'h52AA, shade3 16'h0000.
- Read/write collision on the same address in the same cycle: the read returns the old data. Tearing is accepted; there is no frame double-buffering.
- Extra active lines beyond the window display border; src_y never exceeds GB_H-1 in effect because the window gates it.

Decomposition:
- Package gb_display_pkg:
  - RGB565 palette constants PAL_0..PAL_3
  - GB_W, GB_H
  - framebuffer address width = clog2(GB_W*GB_H) = 15
- One sub-module: gb_framebuffer_ram (simple dual-address RAM, synchronous read, read-old-on-collision).
- Counters, window logic and pipeline stay in gb_frame_scaler.

Test Plan:
- Reset is asserted mid-line with de_in = 1 -> immediately hsync = 1, vsync = 1, de = 0, color = 0. After release, the first active line starts at col 0, row 0.
- Write 23040 pixels with wr_pixel = address % 4, then drive one frame of timing -> expected colours:
  - display row 24, cols 0-2 = FFFF
  - cols 3-5 = AD55
  - cols 6-8 = 52AA
  - rows 24-26 identical
  - row 27 shows source line 1
- Sample rows 0-23 and 456-479 with de_in = 1 -> color = BORDER_COLOR (0000) for every pixel. The de/hsync/vsync outputs equal the inputs delayed by exactly 2 cycles.
- After a full frame of writes, issue 5 extra wr_en pulses -> wr_overflow = 1, and address 23039 still holds its original value. Then assert wr_frame_start with wr_en and wr_pixel = 3 -> address 0 reads shade 3 (0000) at display row 24, col 0.
- Write address 0 in the same cycle it is read -> color shows the old shade on that frame and the new shade on the next frame.
- de_in low between active pixels -> color = 0.

Source files
------------

// File: rtl/gb_display_pkg.sv
// Shared constants for the Game Boy display path: source geometry,
// framebuffer sizing and the four-shade RGB565 palette.
package gb_display_pkg;

    localparam int GB_W     = 160;
    localparam int GB_H     = 144;
    localparam int FB_DEPTH = GB_W * GB_H;
    localparam int FB_AW    = $clog2(FB_DEPTH);

    localparam logic [15:0] PAL_0 = 16'hFFFF;
    localparam logic [15:0] PAL_1 = 16'hAD55;
    localparam logic [15:0] PAL_2 = 16'h52AA;
    localparam logic [15:0] PAL_3 = 16'h0000;

    function automatic logic [15:0] shade_to_rgb(input logic [1:0] shade);
        logic [15:0] rgb;
        case (shade)
            2'd0:    rgb = PAL_0;
            2'd1:    rgb = PAL_1;
            2'd2:    rgb = PAL_2;
            default: rgb = PAL_3;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/gb_framebuffer_ram.sv
// Simple dual-address framebuffer: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module gb_framebuffer_ram
    import gb_display_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = FB_AW,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gb_frame_scaler.sv
// Stores the PPU pixel stream and replays it integer-upscaled and centred
// against external LCD timing, with a two-cycle aligned sync/colour pipeline.
module gb_frame_scaler
    import gb_display_pkg::*;
#(
    parameter int          SCALE        = 3,
    parameter int          WIDTH        = 480,
    parameter int          HEIGHT       = 480,
    parameter int          V_OFFSET     = (HEIGHT - GB_H * SCALE) / 2,
    parameter int          H_OFFSET     = 0,
    parameter logic [15:0] BORDER_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_pixel,
    input  logic        wr_frame_start,
    output logic        wr_overflow,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] color
);

    localparam int COL_W = $clog2(WIDTH) + 1;
    localparam int ROW_W = $clog2(HEIGHT) + 1;
    localparam int PH_W  = $clog2(SCALE + 1);
    localparam int SX_W  = $clog2(GB_W + 1);
    localparam int SY_W  = $clog2(GB_H + 1);

    localparam logic [COL_W-1:0] H_START   = COL_W'(H_OFFSET);
    localparam logic [COL_W-1:0] H_SPAN    = COL_W'(GB_W * SCALE);
    localparam logic [ROW_W-1:0] V_START   = ROW_W'(V_OFFSET);
    localparam logic [ROW_W-1:0] V_SPAN    = ROW_W'(GB_H * SCALE);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(SCALE - 1);
    localparam logic [SY_W-1:0]  SY_LIMIT  = SY_W'(GB_H);
    localparam logic [FB_AW-1:0] WR_LIMIT  = FB_AW'(FB_DEPTH);
    localparam logic [FB_AW-1:0] LINE_STEP = FB_AW'(GB_W);

    // ---------------- write side ----------------
    logic [FB_AW-1:0] wr_addr_q, wr_addr_d;
    logic             wr_overflow_q, wr_overflow_d;
    logic             ram_we;
    logic [FB_AW-1:0] ram_waddr;

    always_comb begin
        wr_addr_d     = wr_addr_q;
        wr_overflow_d = wr_overflow_q;
        ram_we        = 1'b0;
        ram_waddr     = wr_addr_q;
        if (wr_frame_start) begin
            ram_waddr = '0;
            ram_we    = wr_en;
            wr_addr_d = wr_en ? FB_AW'(1) : '0;
        end else if (wr_en) begin
            if (wr_addr_q < WR_LIMIT) begin
                ram_we    = 1'b1;
                wr_addr_d = wr_addr_q + FB_AW'(1);
            end else begin
                wr_overflow_d = 1'b1;
            end
        end
    end

    // ---------------- read-address generation ----------------
    logic [COL_W-1:0] col_q, col_d;
    logic [PH_W-1:0]  h_phase_q, h_phase_d;
    logic [SX_W-1:0]  src_x_q, src_x_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PH_W-1:0]  v_phase_q, v_phase_d;
    logic [SY_W-1:0]  src_y_q, src_y_d;
    logic [FB_AW-1:0] line_base_q, line_base_d;
    logic             de_prev_q;

    logic             de_fall, h_win, v_win, in_window;
    logic [COL_W-1:0] h_rel;
    logic [ROW_W-1:0] v_rel;
    logic [FB_AW-1:0] rd_addr;
    logic [1:0]       rd_shade;

    // Offset-relative compare: positions before the window wrap to large values.
    assign h_rel     = col_q - H_START;
    assign v_rel     = row_q - V_START;
    assign h_win     = h_rel < H_SPAN;
    assign v_win     = (v_rel < V_SPAN) && (src_y_q < SY_LIMIT);
    assign de_fall   = de_prev_q & ~de_in;
    assign in_window = de_in & h_win & v_win;
    assign rd_addr   = line_base_q + FB_AW'(src_x_q);

    always_comb begin
        col_d       = col_q;
        h_phase_d   = h_phase_q;
        src_x_d     = src_x_q;
        row_d       = row_q;
        v_phase_d   = v_phase_q;
        src_y_d     = src_y_q;
        line_base_d = line_base_q;
        if (de_in) begin
            col_d = col_q + COL_W'(1);
            if (h_win) begin
                if (h_phase_q == PH_LAST) begin
                    h_phase_d = '0;
                    src_x_d   = src_x_q + SX_W'(1);
                end else begin
                    h_phase_d = h_phase_q + PH_W'(1);
                end
            end
        end
        if (de_fall) begin
            col_d     = '0;
            h_phase_d = '0;
            src_x_d   = '0;
            row_d     = row_q + ROW_W'(1);
            if (v_win) begin
                if (v_phase_q == PH_LAST) begin
                    v_phase_d   = '0;
                    src_y_d     = src_y_q + SY_W'(1);
                    line_base_d = line_base_q + LINE_STEP;
                end else begin
                    v_phase_d = v_phase_q + PH_W'(1);
                end
            end
        end
        if (!vsync_in) begin
            row_d       = '0;
            v_phase_d   = '0;
            src_y_d     = '0;
            line_base_d = '0;
        end
    end

    gb_framebuffer_ram u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_data_i (wr_pixel),
        .rd_en_i   (in_window),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_shade)
    );

    // ---------------- output pipeline ----------------
    logic        s1_hsync_q, s1_vsync_q, s1_de_q, s1_win_q;
    logic        hsync_q, vsync_q, de_q;
    logic [15:0] color_q, color_d;

    always_comb begin
        color_d = 16'h0000;
        if (s1_de_q) begin
            color_d = s1_win_q ? shade_to_rgb(rd_shade) : BORDER_COLOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr_q     <= '0;
            wr_overflow_q <= 1'b0;
            col_q         <= '0;
            h_phase_q     <= '0;
            src_x_q       <= '0;
            row_q         <= '0;
            v_phase_q     <= '0;
            src_y_q       <= '0;
            line_base_q   <= '0;
            de_prev_q     <= 1'b0;
            s1_hsync_q    <= 1'b1;
            s1_vsync_q    <= 1'b1;
            s1_de_q       <= 1'b0;
            s1_win_q      <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            color_q       <= 16'h0000;
        end else begin
            wr_addr_q     <= wr_addr_d;
            wr_overflow_q <= wr_overflow_d;
            col_q         <= col_d;
            h_phase_q     <= h_phase_d;
            src_x_q       <= src_x_d;
            row_q         <= row_d;
            v_phase_q     <= v_phase_d;
            src_y_q       <= src_y_d;
            line_base_q   <= line_base_d;
            de_prev_q     <= de_in;
            s1_hsync_q    <= hsync_in;
            s1_vsync_q    <= vsync_in;
            s1_de_q       <= de_in;
            s1_win_q      <= in_window;
            hsync_q       <= s1_hsync_q;
            vsync_q       <= s1_vsync_q;
            de_q          <= s1_de_q;
            color_q       <= color_d;
        end
    end

    assign wr_overflow = wr_overflow_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign color       = color_q;

endmodule

// File: tb/tb_gb_frame_scaler.sv
// Directed bench for gb_frame_scaler: reset, full-frame write, overflow,
// frame restart, read/write collision and border/blanking colour.
module tb_gb_frame_scaler;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_pixel;
    logic        wr_frame_start;
    logic        wr_overflow;
    logic        hsync_in, vsync_in, de_in;
    logic        hsync, vsync, de;
    logic [15:0] color;

    gb_frame_scaler dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_pixel       (wr_pixel),
        .wr_frame_start (wr_frame_start),
        .wr_overflow    (wr_overflow),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .de_in          (de_in),
        .hsync          (hsync),
        .vsync          (vsync),
        .de             (de),
        .color          (color)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        h;
        logic        v;
        logic        d;
        logic [15:0] c;
        int          f;
        int          r;
        int          col;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  mem_m [23040];
    logic [15:0] pal [4];
    int          wa_m;
    logic        ovf_m;
    logic        coll_arm;
    int          frame_no;
    int          checks = 0;
    int          errors = 0;

    logic [15:0] cap24  [5][9];
    logic [15:0] cap25  [5];
    logic [15:0] cap27  [5];
    logic [15:0] cap455 [5];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv,
                       input int f, input int r, input int c);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s frame %0d row %0d col %0d observed %h expected %h",
                   tag, f, r, c, obs, expv);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int r, input int c);
        int addr;
        if (r >= 24 && r < 456 && c < 480) begin
            addr = ((r - 24) / 3) * 160 + (c / 3);
            return pal[mem_m[addr]];
        end
        return 16'h0000;
    endfunction

    task automatic idle_hist();
        exp_t e;
        e.h = 1'b1; e.v = 1'b1; e.d = 1'b0; e.c = 16'h0000;
        e.f = frame_no; e.r = -1; e.col = -1;
        exp_q.delete();
        exp_q.push_back(e);
        exp_q.push_back(e);
    endtask

    // One pixel clock: check outputs due now, then apply the next inputs.
    task automatic cyc(input logic fs, input logic en, input logic [1:0] px,
                       input logic h, input logic v, input logic d,
                       input logic [15:0] ec, input int r, input int c);
        exp_t e;
        @(negedge clk);
        e = exp_q.pop_front();
        chk("hsync", {15'd0, hsync}, {15'd0, e.h}, e.f, e.r, e.col);
        chk("vsync", {15'd0, vsync}, {15'd0, e.v}, e.f, e.r, e.col);
        chk("de", {15'd0, de}, {15'd0, e.d}, e.f, e.r, e.col);
        chk("color", color, e.c, e.f, e.r, e.col);
        chk("wr_overflow", {15'd0, wr_overflow}, {15'd0, ovf_m}, e.f, e.r, e.col);
        if (e.r == 24 && e.col >= 0 && e.col < 9) cap24[e.f][e.col] = color;
        if (e.r == 25 && e.col == 0) cap25[e.f] = color;
        if (e.r == 27 && e.col == 0) cap27[e.f] = color;
        if (e.r == 455 && e.col == 479) cap455[e.f] = color;

        wr_frame_start = fs;
        wr_en          = en;
        wr_pixel       = px;
        hsync_in       = h;
        vsync_in       = v;
        de_in          = d;
        e.h = h; e.v = v; e.d = d; e.c = d ? ec : 16'h0000;
        e.f = frame_no; e.r = r; e.col = c;
        exp_q.push_back(e);

        if (fs) begin
            if (en) begin
                mem_m[0] = px;
                wa_m = 1;
            end else begin
                wa_m = 0;
            end
        end else if (en) begin
            if (wa_m < 23040) begin
                mem_m[wa_m] = px;
                wa_m++;
            end else begin
                ovf_m = 1'b1;
            end
        end
    endtask

    task automatic line(input int r, input int len);
        logic f;
        for (int c = 0; c < len; c++) begin
            f = coll_arm && (r == 24) && (c == 0);
            cyc(f, f, 2'd1, 1'b1, 1'b1, 1'b1, exp_pix(r, c), r, c);
        end
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000, r, -1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000, r, -1);
    endtask

    task automatic frame();
        int len;
        for (int r = 0; r < 480; r++) begin
            if (r >= 24 && r <= 27)        len = 12;
            else if (r == 455)             len = 480;
            else if (r == 23 || r == 456)  len = 6;
            else                           len = 2;
            line(r, len);
        end
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0000, -1, -1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0000, -1, -1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000, -1, -1);
    endtask

    initial begin
        pal[0] = 16'hFFFF; pal[1] = 16'hAD55; pal[2] = 16'h52AA; pal[3] = 16'h0000;
        wa_m = 0; ovf_m = 1'b0; coll_arm = 1'b0; frame_no = 0;
        reset = 1'b1; wr_en = 1'b0; wr_pixel = 2'd0; wr_frame_start = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_hist();

        // A few lines, then reset mid-line with de_in still high.
        for (int r = 0; r < 5; r++) line(r, 3);
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 16'h0000, 5, c);
        @(negedge clk);
        chk("pre_reset_de", {15'd0, de}, 16'd1, 0, 5, 2);
        reset = 1'b1;
        #1;
        chk("reset_hsync", {15'd0, hsync}, 16'd1, 0, -1, -1);
        chk("reset_vsync", {15'd0, vsync}, 16'd1, 0, -1, -1);
        chk("reset_de", {15'd0, de}, 16'd0, 0, -1, -1);
        chk("reset_color", color, 16'h0000, 0, -1, -1);
        chk("reset_ovf", {15'd0, wr_overflow}, 16'd0, 0, -1, -1);
        @(negedge clk);
        de_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle_hist();

        // Full frame of writes, shade = address % 4, then overflow attempts.
        for (int i = 0; i < 23040; i++)
            cyc(1'b0, 1'b1, 2'(i % 4), 1'b1, 1'b1, 1'b0, 16'h0000, -1, -1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000, -1, -1);
        chk("ovf_at_full", {15'd0, wr_overflow}, 16'd0, 0, -1, -1);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000, -1, -1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000, -1, -1);
        chk("ovf_after_extra", {15'd0, wr_overflow}, 16'd1, 0, -1, -1);

        // Frame 1 follows reset directly: rows count from 0 without a vsync.
        frame_no = 1;
        frame();

        // Restart the write address and overwrite address 0 with shade 3.
        frame_no = 2;
        cyc(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 16'h0000, -1, -1);
        frame();

        // Write address 0 (shade 1) in the cycle it is read.
        frame_no = 3;
        coll_arm = 1'b1;
        frame();
        coll_arm = 1'b0;

        frame_no = 4;
        frame();
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000, -1, -1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000, -1, -1);

        // Hand-computed spot values.
        chk("f1_r24_c0", cap24[1][0], 16'hFFFF, 1, 24, 0);
        chk("f1_r24_c2", cap24[1][2], 16'hFFFF, 1, 24, 2);
        chk("f1_r24_c3", cap24[1][3], 16'hAD55, 1, 24, 3);
        chk("f1_r24_c5", cap24[1][5], 16'hAD55, 1, 24, 5);
        chk("f1_r24_c6", cap24[1][6], 16'h52AA, 1, 24, 6);
        chk("f1_r24_c8", cap24[1][8], 16'h52AA, 1, 24, 8);
        chk("f1_r455_c479", cap455[1], 16'h0000, 1, 455, 479);
        chk("f2_r24_c0", cap24[2][0], 16'h0000, 2, 24, 0);
        chk("f2_r25_c0", cap25[2], 16'h0000, 2, 25, 0);
        chk("f2_r27_c0", cap27[2], 16'hFFFF, 2, 27, 0);
        chk("f2_r455_c479", cap455[2], 16'h0000, 2, 455, 479);
        chk("f3_r24_c0_old", cap24[3][0], 16'h0000, 3, 24, 0);
        chk("f3_r24_c1_new", cap24[3][1], 16'hAD55, 3, 24, 1);
        chk("f3_r25_c0", cap25[3], 16'hAD55, 3, 25, 0);
        chk("f4_r24_c0", cap24[4][0], 16'hAD55, 4, 24, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
